// File: rtl/fir_filter_pipe.sv
// Handshaked direct-form FIR core: runtime tap writes, delay-line flush, per-sample bypass,
// and a 3-stage product / sum / round-saturate pipeline with fixed latency.
module fir_filter_pipe #(
   parameter int DATA_W    = 32,
   parameter int COEF_W    = 32,
   parameter int NTAPS     = 16,
   parameter int OUT_W     = 64,
   parameter int OUT_SHIFT = 0
) (
   input  logic                   CLK,
   input  logic                   areset_n,
   input  logic                   en_FIR,
   input  logic                   tap_we,
   input  logic [$clog2(NTAPS):0] tap_idx,
   input  logic [COEF_W-1:0]      tap_val,
   input  logic                   clr_hist,
   input  logic                   in_valid,
   input  logic [DATA_W-1:0]      in_data,
   output logic                   out_valid,
   output logic [OUT_W-1:0]       out_data,
   output logic                   tap_err
);

   localparam int IDX_W   = $clog2(NTAPS);
   localparam int PROD_W  = DATA_W + COEF_W;
   localparam int ACC_W   = DATA_W + COEF_W + IDX_W;
   localparam int CMP_W   = (ACC_W + 1 > OUT_W) ? ACC_W + 1 : OUT_W;
   localparam int RND_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
   localparam logic [IDX_W:0] TAP_LIM = (IDX_W + 1)'(NTAPS);
   localparam logic signed [CMP_W-1:0] RND_ADD =
      (OUT_SHIFT > 0) ? (CMP_W'(1) << RND_POS) : '0;
   localparam logic signed [CMP_W-1:0] SAT_MAX = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [CMP_W-1:0] SAT_MIN = {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [COEF_W-1:0] tap_q  [NTAPS];
   logic signed [DATA_W-1:0] x_q    [NTAPS];
   logic signed [DATA_W-1:0] x_d    [NTAPS];
   logic signed [PROD_W-1:0] prod_q [NTAPS];
   logic signed [ACC_W-1:0]  acc_d, acc_q;
   logic signed [DATA_W-1:0] byp1_q, byp2_q;
   logic signed [CMP_W-1:0]  rnd, shf;
   logic signed [OUT_W-1:0]  res_d;
   logic                     v0_q, v1_q, v2_q, en0_q, en1_q, en2_q;
   logic                     tap_ok, tap_bad;
   logic                     out_valid_q, tap_err_q;
   logic [OUT_W-1:0]         out_data_q;

   assign tap_ok  = tap_we && (tap_idx < TAP_LIM);
   assign tap_bad = tap_we && (tap_idx >= TAP_LIM);

   // A flush on the accepting edge still keeps the incoming sample in x[0].
   always_comb begin
      for (int k = 0; k < NTAPS; k++) x_d[k] = clr_hist ? '0 : x_q[k];
      if (in_valid) begin
         x_d[0] = in_data;
         for (int k = 1; k < NTAPS; k++) x_d[k] = clr_hist ? '0 : x_q[k-1];
      end
   end

   always_ff @(posedge CLK) begin
      if (!areset_n) begin
         for (int k = 0; k < NTAPS; k++) begin
            tap_q[k] <= '0;
            x_q[k]   <= '0;
         end
         v0_q        <= 1'b0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         en0_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         tap_err_q   <= 1'b0;
      end else begin
         if (tap_ok) tap_q[tap_idx[IDX_W-1:0]] <= tap_val;
         tap_err_q <= tap_bad;
         for (int k = 0; k < NTAPS; k++) x_q[k] <= x_d[k];
         v0_q        <= in_valid;
         en0_q       <= en_FIR;
         v1_q        <= v0_q;
         v2_q        <= v1_q;
         out_valid_q <= v2_q;
         if (v2_q) out_data_q <= res_d;
      end
   end

   // Data stages advance only with their valid; the valids above carry reset.
   always_ff @(posedge CLK) begin
      if (v0_q) begin
         for (int k = 0; k < NTAPS; k++) prod_q[k] <= PROD_W'(tap_q[k]) * PROD_W'(x_q[k]);
         byp1_q <= x_q[0];
         en1_q  <= en0_q;
      end
      if (v1_q) begin
         acc_q  <= acc_d;
         byp2_q <= byp1_q;
         en2_q  <= en1_q;
      end
   end

   always_comb begin
      acc_d = '0;
      for (int k = 0; k < NTAPS; k++) acc_d = acc_d + ACC_W'(prod_q[k]);
   end

   always_comb begin
      rnd = CMP_W'(acc_q) + RND_ADD;
      shf = rnd >>> OUT_SHIFT;
      if (!en2_q)              res_d = OUT_W'(byp2_q);
      else if (shf > SAT_MAX)  res_d = SAT_MAX[OUT_W-1:0];
      else if (shf < SAT_MIN)  res_d = SAT_MIN[OUT_W-1:0];
      else                     res_d = shf[OUT_W-1:0];
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign tap_err   = tap_err_q;

endmodule

// File: tb/tb_fir_filter_pipe.sv
// Bench for fir_filter_pipe: two instances (64-bit unshifted, 32-bit with shift 2) share one
// stimulus stream and are checked against a plain-arithmetic FIR model with timestamped queues.
module tb_fir_filter_pipe;
   localparam int NT = 16;

   logic        CLK = 1'b0;
   logic        areset_n = 1'b0;
   logic        en_FIR = 1'b0, tap_we = 1'b0, clr_hist = 1'b0, in_valid = 1'b0;
   logic [4:0]  tap_idx = '0;
   logic [31:0] tap_val = '0, in_data = '0;
   logic        out_valid_a, tap_err_a, out_valid_b, tap_err_b;
   logic [63:0] out_data_a;
   logic [31:0] out_data_b;

   fir_filter_pipe dut_a (
      .CLK(CLK), .areset_n(areset_n), .en_FIR(en_FIR), .tap_we(tap_we), .tap_idx(tap_idx),
      .tap_val(tap_val), .clr_hist(clr_hist), .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid_a), .out_data(out_data_a), .tap_err(tap_err_a));

   fir_filter_pipe #(.OUT_W(32), .OUT_SHIFT(2)) dut_b (
      .CLK(CLK), .areset_n(areset_n), .en_FIR(en_FIR), .tap_we(tap_we), .tap_idx(tap_idx),
      .tap_val(tap_val), .clr_hist(clr_hist), .in_valid(in_valid), .in_data(in_data),
      .out_valid(out_valid_b), .out_data(out_data_b), .tap_err(tap_err_b));

   always #5 CLK = ~CLK;

   int n_checks = 0, n_errors = 0;
   int cyc = 0;
   logic rst_at_edge = 1'b1;

   logic signed [31:0] m_tap [NT];
   logic signed [31:0] m_x   [NT];
   logic [63:0] exp_a_q[$], exp_b_q[$], log_a[$], log_b[$];
   int          due_q[$], err_q[$];
   logic [63:0] last_a = '0, last_b = '0;
   logic        mon_exp_v, mon_exp_e;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Spec-level output rule: bypass sign-extends; filter rounds half up, shifts, saturates.
   function automatic logic [63:0] ref_out(input logic en, input logic signed [31:0] d,
                                           input logic signed [127:0] s, input int w, input int sh);
      logic signed [127:0] v, mx, mn;
      if (!en) return {{32{d[31]}}, d};
      v = s;
      if (sh > 0) v = (v + (128'sd1 <<< (sh - 1))) >>> sh;
      mx = (128'sd1 <<< (w - 1)) - 128'sd1;
      mn = -(128'sd1 <<< (w - 1));
      if (v > mx) v = mx;
      else if (v < mn) v = mn;
      return v[63:0];
   endfunction

   always @(posedge CLK) begin
      cyc         <= cyc + 1;
      rst_at_edge <= !areset_n;
   end

   always @(negedge CLK) begin : monitor
      if (rst_at_edge) begin
         due_q.delete(); exp_a_q.delete(); exp_b_q.delete(); err_q.delete();
         check_eq("rst_valid_a", {63'b0, out_valid_a}, 64'd0);
         check_eq("rst_data_a", out_data_a, 64'd0);
         check_eq("rst_valid_b", {63'b0, out_valid_b}, 64'd0);
         check_eq("rst_data_b", {32'b0, out_data_b}, 64'd0);
         check_eq("rst_err_a", {63'b0, tap_err_a}, 64'd0);
         last_a = '0;
         last_b = '0;
      end else begin
         while (due_q.size() > 0 && due_q[0] < cyc) begin
            void'(due_q.pop_front()); void'(exp_a_q.pop_front()); void'(exp_b_q.pop_front());
         end
         mon_exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
         check_eq("valid_a", {63'b0, out_valid_a}, {63'b0, mon_exp_v});
         check_eq("valid_b", {63'b0, out_valid_b}, {63'b0, mon_exp_v});
         if (mon_exp_v) begin
            check_eq("data_a", out_data_a, exp_a_q[0]);
            check_eq("data_b", {{32{out_data_b[31]}}, out_data_b}, exp_b_q[0]);
            void'(due_q.pop_front()); void'(exp_a_q.pop_front()); void'(exp_b_q.pop_front());
         end else begin
            check_eq("hold_a", out_data_a, last_a);
            check_eq("hold_b", {32'b0, out_data_b}, last_b);
         end
         if (out_valid_a) begin last_a = out_data_a; log_a.push_back(out_data_a); end
         if (out_valid_b) begin last_b = {32'b0, out_data_b}; log_b.push_back({32'b0, out_data_b}); end
         mon_exp_e = (err_q.size() > 0) && (err_q[0] == cyc);
         check_eq("tap_err_a", {63'b0, tap_err_a}, {63'b0, mon_exp_e});
         check_eq("tap_err_b", {63'b0, tap_err_b}, {63'b0, mon_exp_e});
         if (mon_exp_e) void'(err_q.pop_front());
      end
   end

   // One edge of stimulus; the model is updated for the edge these inputs meet.
   task automatic drive(input logic vld, input logic en, input logic [31:0] d, input logic we,
                        input logic [4:0] idx, input logic [31:0] val, input logic clr);
      logic signed [127:0] s, a, b;
      @(negedge CLK);
      in_valid = vld; en_FIR = en; in_data = d;
      tap_we = we; tap_idx = idx; tap_val = val; clr_hist = clr;
      if (we) begin
         if (idx < 5'(NT)) m_tap[idx[3:0]] = val;
         else err_q.push_back(cyc + 1);
      end
      if (clr) for (int k = 0; k < NT; k++) m_x[k] = '0;
      if (vld) begin
         for (int k = NT - 1; k > 0; k--) m_x[k] = m_x[k-1];
         m_x[0] = d;
         s = '0;
         for (int k = 0; k < NT; k++) begin
            a = m_tap[k];
            b = m_x[k];
            s = s + a * b;
         end
         exp_a_q.push_back(ref_out(en, d, s, 64, 0));
         exp_b_q.push_back(ref_out(en, d, s, 32, 2));
         due_q.push_back(cyc + 4);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b1, '0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic send(input int d, input logic en);
      drive(1'b1, en, d, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic wr_tap(input int i, input int v);
      drive(1'b0, 1'b1, '0, 1'b1, 5'(i), v, 1'b0);
   endtask

   task automatic clear_hist();
      drive(1'b0, 1'b1, '0, 1'b0, '0, '0, 1'b1);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && due_q.size() > 0; i++) idle(1);
      idle(2);
      check_eq("drain_empty", 64'(due_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      areset_n = 1'b0;
      in_valid = 1'b0; tap_we = 1'b0; clr_hist = 1'b0;
      for (int k = 0; k < NT; k++) begin m_tap[k] = '0; m_x[k] = '0; end
      repeat (2) @(negedge CLK);
      areset_n = 1'b1;
   endtask

   initial begin : watchdog
      #400000;
      n_errors++;
      $display("FAIL watchdog: time limit reached");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin : stim
      logic vld, en, we, clr;
      int   d, v;
      for (int k = 0; k < NT; k++) begin m_tap[k] = '0; m_x[k] = '0; end
      repeat (3) @(negedge CLK);
      check_eq("reset_valid", {63'b0, out_valid_a}, 64'd0);
      check_eq("reset_data", out_data_a, 64'd0);
      check_eq("reset_err", {63'b0, tap_err_b}, 64'd0);
      areset_n = 1'b1;

      // Impulse through taps 1..16
      for (int i = 0; i < NT; i++) wr_tap(i, i + 1);
      log_a.delete();
      send(1, 1'b1);
      for (int i = 0; i < NT - 1; i++) send(0, 1'b1);
      drain();
      check_eq("impulse_count", 64'(log_a.size()), 64'd16);
      for (int i = 0; i < NT; i++) check_eq("impulse_val", log_a[i], 64'(i + 1));

      // Same impulse with a gapped stream
      clear_hist();
      log_a.delete();
      send(1, 1'b1); idle(1);
      for (int i = 0; i < NT - 1; i++) begin send(0, 1'b1); idle(1); end
      drain();
      check_eq("gapped_count", 64'(log_a.size()), 64'd16);
      for (int i = 0; i < NT; i++) check_eq("gapped_val", log_a[i], 64'(i + 1));

      // Saturation on the 32-bit instance
      for (int i = 0; i < NT; i++) wr_tap(i, 32'h7FFF_FFFF);
      clear_hist();
      log_b.delete();
      for (int i = 0; i < NT; i++) send(32'h7FFF_FFFF, 1'b1);
      drain();
      check_eq("sat_pos", log_b[$], 64'h7FFF_FFFF);
      for (int i = 0; i < NT; i++) send(32'h8000_0000, 1'b1);
      drain();
      check_eq("sat_neg", log_b[$], 64'h8000_0000);

      // Rounding with shift 2 and a single unit tap
      for (int i = 0; i < NT; i++) wr_tap(i, (i == 0) ? 1 : 0);
      log_b.delete();
      send(6, 1'b1); send(-6, 1'b1); send(5, 1'b1);
      drain();
      check_eq("round_6", log_b[0], 64'd2);
      check_eq("round_m6", log_b[1], 64'h0000_0000_FFFF_FFFF);
      check_eq("round_5", log_b[2], 64'd1);

      // Bypass then re-enable: history keeps the bypassed sample
      for (int i = 0; i < NT; i++) wr_tap(i, i + 1);
      clear_hist();
      log_a.delete(); log_b.delete();
      send(-3, 1'b0); send(0, 1'b1);
      drain();
      check_eq("bypass_a", log_a[0], 64'hFFFF_FFFF_FFFF_FFFD);
      check_eq("bypass_b", log_b[0], 64'h0000_0000_FFFF_FFFD);
      check_eq("reenable_a", log_a[1], 64'hFFFF_FFFF_FFFF_FFFA);

      // Out-of-range tap writes leave taps alone
      wr_tap(16, 32'h1234); idle(1); wr_tap(31, 32'h5678);
      clear_hist();
      log_a.delete();
      send(1, 1'b1); send(0, 1'b1);
      drain();
      check_eq("bad_idx_tap0", log_a[0], 64'd1);
      check_eq("bad_idx_tap1", log_a[1], 64'd2);

      // Flush mid-stream together with an accepted sample
      log_a.delete();
      send(5, 1'b1); send(7, 1'b1);
      drive(1'b1, 1'b1, 9, 1'b0, '0, '0, 1'b1);
      send(0, 1'b1);
      drain();
      check_eq("clr_same_edge", log_a[2], 64'd9);
      check_eq("clr_after", log_a[3], 64'd18);

      // Reset with two samples in flight
      log_a.delete(); log_b.delete();
      send(10, 1'b1); send(11, 1'b1);
      do_reset();
      idle(6);
      check_eq("inflight_dropped", 64'(log_a.size() + log_b.size()), 64'd0);
      check_eq("inflight_data", out_data_a, 64'd0);

      // Randomised traffic: small values first, then full range
      for (int phase = 0; phase < 2; phase++) begin
         for (int i = 0; i < NT; i++)
            wr_tap(i, (phase == 0) ? $urandom_range(0, 400) - 200 : int'($urandom));
         for (int i = 0; i < 350; i++) begin
            vld = ($urandom_range(0, 3) != 0);
            en  = ($urandom_range(0, 7) != 0);
            we  = ($urandom_range(0, 9) == 0);
            clr = ($urandom_range(0, 31) == 0);
            d   = (phase == 0) ? $urandom_range(0, 2000) - 1000 : int'($urandom);
            v   = (phase == 0) ? $urandom_range(0, 400) - 200 : int'($urandom);
            drive(vld, en, d, we, 5'($urandom_range(0, 20)), v, clr);
         end
         drain();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
